// File: rtl/regfile_wb_sink_if.sv
// Writeback-to-regfile and decode-to-regfile signal bundle.
// master : pipeline side (writeback write port, decode read/issue requests)
// slave  : register file side (read data, busy flags, AnyBusy)
// Signals:
//   WriteRegW/WriteEnableW/WriteDataW  writeback write port
//   Rs1D/Rs2D -> RD1D/RD2D             decode read ports (combinational)
//   IssueValidD/IssueRdD               pending-write set request
//   BusyRs1D/BusyRs2D/AnyBusy          hazard flags
interface regfile_wb_sink_if #(
    parameter int unsigned XLEN = 32
);
    logic [4:0]      WriteRegW;
    logic            WriteEnableW;
    logic [XLEN-1:0] WriteDataW;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic            IssueValidD;
    logic [4:0]      IssueRdD;
    logic            BusyRs1D;
    logic            BusyRs2D;
    logic            AnyBusy;

    modport master (
        output WriteRegW, WriteEnableW, WriteDataW, Rs1D, Rs2D, IssueValidD, IssueRdD,
        input  RD1D, RD2D, BusyRs1D, BusyRs2D, AnyBusy
    );

    modport slave (
        input  WriteRegW, WriteEnableW, WriteDataW, Rs1D, Rs2D, IssueValidD, IssueRdD,
        output RD1D, RD2D, BusyRs1D, BusyRs2D, AnyBusy
    );
endinterface

// File: rtl/regfile_wb_sink.sv
// Architectural integer register file (32 x XLEN) with writeback write port, two
// combinational decode read ports with optional write-to-read bypass, and a
// per-register pending-write scoreboard.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears array, pending bits, AnyBusy)
//   bus   : regfile_wb_sink_if.slave (write port, read ports, issue, busy flags)
module regfile_wb_sink #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_sink_if.slave    bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             any_busy_q;

    logic wr_hit1;
    logic wr_hit2;

    // Writes to x0 never count as a hit: x0 is hardwired and never pending.
    assign wr_hit1 = bus.WriteEnableW && (bus.WriteRegW == bus.Rs1D) && (bus.Rs1D != 5'd0);
    assign wr_hit2 = bus.WriteEnableW && (bus.WriteRegW == bus.Rs2D) && (bus.Rs2D != 5'd0);

    // Scoreboard next state; set beats clear so a newly issued writer keeps ownership.
    always_comb begin
        pending_d = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            logic set_r;
            logic clr_r;
            set_r = bus.IssueValidD && (bus.IssueRdD == r[4:0]);
            clr_r = bus.WriteEnableW && (bus.WriteRegW == r[4:0]);
            pending_d[r] = set_r || (pending_q[r] && !clr_r);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            any_busy_q <= 1'b0;
        end else begin
            if (bus.WriteEnableW && (bus.WriteRegW != 5'd0)) begin
                regs_q[bus.WriteRegW] <= bus.WriteDataW;
            end
            pending_q  <= pending_d;
            any_busy_q <= |pending_d;
        end
    end

    // Reads are gated by rst_n so an in-flight write cannot leak through the
    // bypass path while the array is held cleared.
    always_comb begin
        bus.RD1D = '0;
        bus.RD2D = '0;
        if (rst_n) begin
            if (bus.Rs1D != 5'd0) begin
                bus.RD1D = (BYPASS_EN && wr_hit1) ? bus.WriteDataW : regs_q[bus.Rs1D];
            end
            if (bus.Rs2D != 5'd0) begin
                bus.RD2D = (BYPASS_EN && wr_hit2) ? bus.WriteDataW : regs_q[bus.Rs2D];
            end
        end
    end

    // A retiring write that is bypassed is not a hazard.
    assign bus.BusyRs1D = pending_q[bus.Rs1D] && !(wr_hit1 && BYPASS_EN);
    assign bus.BusyRs2D = pending_q[bus.Rs2D] && !(wr_hit2 && BYPASS_EN);
    assign bus.AnyBusy  = any_busy_q;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench: stimulus pushes expected values, a monitor samples the two
// DUTs (bypass on / bypass off) and pops/compares.
module tb_regfile_wb_sink;

    logic        clk;
    logic        rst_n;
    logic [4:0]  wr_reg;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iss_v;
    logic [4:0]  iss_rd;

    regfile_wb_sink_if #(.XLEN(32)) bus_b ();
    regfile_wb_sink_if #(.XLEN(32)) bus_n ();

    assign bus_b.WriteRegW    = wr_reg;
    assign bus_b.WriteEnableW = wr_en;
    assign bus_b.WriteDataW   = wr_data;
    assign bus_b.Rs1D         = rs1;
    assign bus_b.Rs2D         = rs2;
    assign bus_b.IssueValidD  = iss_v;
    assign bus_b.IssueRdD     = iss_rd;
    assign bus_n.WriteRegW    = wr_reg;
    assign bus_n.WriteEnableW = wr_en;
    assign bus_n.WriteDataW   = wr_data;
    assign bus_n.Rs1D         = rs1;
    assign bus_n.Rs2D         = rs2;
    assign bus_n.IssueValidD  = iss_v;
    assign bus_n.IssueRdD     = iss_rd;

    regfile_wb_sink #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    regfile_wb_sink #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        SelRd1B, SelRd2B, SelBusy1B, SelBusy2B, SelAnyB,
        SelRd1N, SelRd2N, SelBusy1N, SelAnyN
    } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;
    event chk_ev;

    function automatic logic [31:0] sample(input sel_e s);
        case (s)
            SelRd1B:   return bus_b.RD1D;
            SelRd2B:   return bus_b.RD2D;
            SelBusy1B: return {31'd0, bus_b.BusyRs1D};
            SelBusy2B: return {31'd0, bus_b.BusyRs2D};
            SelAnyB:   return {31'd0, bus_b.AnyBusy};
            SelRd1N:   return bus_n.RD1D;
            SelRd2N:   return bus_n.RD2D;
            SelBusy1N: return {31'd0, bus_n.BusyRs1D};
            SelAnyN:   return {31'd0, bus_n.AnyBusy};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: samples 2 time units after each check request (clear of edges).
    initial begin
        forever begin
            @(chk_ev);
            #2;
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e   = sb_q.pop_front();
                act = sample(e.sel);
                n_checks++;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input string name, input sel_e sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic check_now();
        -> chk_ev;
        #3;
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n   = 1'b0;
        wr_reg  = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        rs1     = '0;
        rs2     = '0;
        iss_v   = 1'b0;
        iss_rd  = '0;

        // Reset state
        @(negedge clk);
        rs1 = 5'd3;
        expect_v("reset_rd1", SelRd1B, 32'h0);
        expect_v("reset_any", SelAnyB, 32'h0);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write/read
        wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'h1234_5678;
        tick();
        wr_en = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
        expect_v("basic_rd1_b", SelRd1B, 32'h1234_5678);
        expect_v("basic_rd2_b", SelRd2B, 32'h1234_5678);
        expect_v("basic_rd1_n", SelRd1N, 32'h1234_5678);
        expect_v("basic_rd2_n", SelRd2N, 32'h1234_5678);
        check_now();

        // x0 protection, including bypass and issue of x0
        wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'hFFFF_FFFF; rs1 = 5'd0;
        iss_v = 1'b1; iss_rd = 5'd0;
        expect_v("x0_same_cycle_b", SelRd1B, 32'h0);
        expect_v("x0_same_cycle_n", SelRd1N, 32'h0);
        check_now();
        tick();
        wr_en = 1'b0; iss_v = 1'b0;
        expect_v("x0_after_b", SelRd1B, 32'h0);
        expect_v("x0_busy_b", SelBusy1B, 32'h0);
        expect_v("x0_any_b", SelAnyB, 32'h0);
        check_now();

        // Bypass
        wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'hA;
        tick();
        wr_data = 32'hB; rs2 = 5'd9;
        expect_v("bypass_on_rd2", SelRd2B, 32'hB);
        expect_v("bypass_off_rd2", SelRd2N, 32'hA);
        check_now();
        tick();
        wr_en = 1'b0;
        expect_v("bypass_after_b", SelRd2B, 32'hB);
        expect_v("bypass_after_n", SelRd2N, 32'hB);
        check_now();

        // Scoreboard lifecycle on x4
        iss_v = 1'b1; iss_rd = 5'd4; rs1 = 5'd4;
        expect_v("sb_c0_busy", SelBusy1B, 32'h0);
        check_now();
        tick();
        iss_v = 1'b0;
        expect_v("sb_c1_busy_b", SelBusy1B, 32'h1);
        expect_v("sb_c1_busy_n", SelBusy1N, 32'h1);
        expect_v("sb_c1_any", SelAnyB, 32'h1);
        check_now();
        tick();
        expect_v("sb_c2_busy_b", SelBusy1B, 32'h1);
        check_now();
        tick();
        wr_en = 1'b1; wr_reg = 5'd4; wr_data = 32'h55;
        expect_v("sb_c3_busy_b", SelBusy1B, 32'h0);
        expect_v("sb_c3_rd1_b", SelRd1B, 32'h55);
        expect_v("sb_c3_busy_n", SelBusy1N, 32'h1);
        expect_v("sb_c3_rd1_n", SelRd1N, 32'h0);
        check_now();
        tick();
        wr_en = 1'b0;
        expect_v("sb_after_any_b", SelAnyB, 32'h0);
        expect_v("sb_after_any_n", SelAnyN, 32'h0);
        expect_v("sb_after_rd1", SelRd1B, 32'h55);
        check_now();

        // Simultaneous set/clear on x6: set wins
        iss_v = 1'b1; iss_rd = 5'd6;
        tick();
        wr_en = 1'b1; wr_reg = 5'd6; wr_data = 32'h66;
        tick();
        iss_v = 1'b0; wr_en = 1'b0; rs1 = 5'd6; rs2 = 5'd6;
        expect_v("setclr_busy1", SelBusy1B, 32'h1);
        expect_v("setclr_busy2", SelBusy2B, 32'h1);
        expect_v("setclr_any", SelAnyB, 32'h1);
        expect_v("setclr_rd1", SelRd1B, 32'h66);
        expect_v("setclr_rd1_n", SelRd1N, 32'h66);
        check_now();
        wr_en = 1'b1; wr_reg = 5'd6; wr_data = 32'h67;
        tick();
        wr_en = 1'b0;
        expect_v("setclr_final_any", SelAnyB, 32'h0);
        expect_v("setclr_final_rd1", SelRd1B, 32'h67);
        check_now();

        // Clear on non-pending register still writes data
        wr_en = 1'b1; wr_reg = 5'd10; wr_data = 32'h1010;
        tick();
        wr_en = 1'b0; rs1 = 5'd10;
        expect_v("clr_nonpend_rd1", SelRd1B, 32'h1010);
        expect_v("clr_nonpend_any", SelAnyB, 32'h0);
        check_now();

        // Reset mid-run
        wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0; iss_v = 1'b1; iss_rd = 5'd7;
        tick();
        iss_v = 1'b0; rs1 = 5'd5; rs2 = 5'd7;
        expect_v("pre_rst_rd1", SelRd1B, 32'hDEAD_BEEF);
        expect_v("pre_rst_busy2", SelBusy2B, 32'h1);
        expect_v("pre_rst_any", SelAnyB, 32'h1);
        check_now();
        // In-flight write to x5 held during reset must not appear on the read port.
        wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hCAFE_F00D;
        rst_n = 1'b0;
        expect_v("rst_rd1_b", SelRd1B, 32'h0);
        expect_v("rst_rd1_n", SelRd1N, 32'h0);
        expect_v("rst_any", SelAnyB, 32'h0);
        check_now();
        rs1 = 5'd7;
        expect_v("rst_busy1", SelBusy1B, 32'h0);
        check_now();
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rs1 = 5'd5;
        expect_v("post_rst_rd1", SelRd1B, 32'h0);
        expect_v("post_rst_any", SelAnyB, 32'h0);
        check_now();
        tick();

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Architectural integer register file: 32 x 32-bit. It is the receiving end of the writeback-stage write interface (WriteRegW / WriteEnableW / WriteDataW).
- Provides two decode-stage read ports, with same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard. Decode sets a pending bit at issue; writeback clears it. Hazard logic reads the busy flags.

Parameters:
- XLEN, 32, data width of each register and of the write/read data ports
- NREGS, 32, number of architectural registers; address width is clog2(NREGS)
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns WriteDataW; 0 = returns the old value

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- WriteRegW  input  5  destination register from writeback
- WriteEnableW  input  1  write strobe from writeback
- WriteDataW  input  XLEN  write data from writeback
- Rs1D  input  5  read address, port 1
- Rs2D  input  5  read address, port 2
- RD1D  output  XLEN  read data, port 1 (combinational)
- RD2D  output  XLEN  read data, port 2 (combinational)
- IssueValidD  input  1  an instruction with a destination register issues this cycle
- IssueRdD  input  5  destination register of the issuing instruction
- BusyRs1D  output  1  Rs1D has a pending write not yet retired (combinational)
- BusyRs2D  output  1  Rs2D has a pending write not yet retired (combinational)
- AnyBusy  output  1  OR of all pending bits (registered view, includes this-cycle updates after the edge)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
  - While rst_n=0: all registers = 0, all pending bits = 0, AnyBusy = 0.
  - Reset asserted mid-operation discards an in-flight write and all pending bits immediately, without waiting for a clock edge.
  - Read outputs during reset reflect the cleared array, i.e. 0.
- Write: on a rising clk edge with WriteEnableW=1 and WriteRegW!=0, regs[WriteRegW] <= WriteDataW. Write latency: visible in the array one edge later.
- Register x0:
  - Writes to x0 are silently dropped.
  - Reads of x0 always return 0, including under bypass.
  - The x0 pending bit is never set, so BusyRsN for x0 = 0.
- Read: RDnD = 0 if RsnD==0.
  - Otherwise, if BYPASS_EN and WriteEnableW and WriteRegW==RsnD, RDnD = WriteDataW.
  - Otherwise RDnD = regs[RsnD].
  - Pure combinational. No read latency.
- Scoreboard update per edge, for register r != 0:
  - Set term: IssueValidD && IssueRdD==r.
  - Clear term: WriteEnableW && WriteRegW==r.
  - Set and clear on the same r in the same cycle: set wins. The newer instruction owns the register.
  - Set on an already-pending r: stays 1. No counting; the pipeline allows only one in-flight writer per register, and hazard logic stalls otherwise.
  - Clear on a non-pending r: no effect, and the data write still occurs.
- Busy outputs: BusyRsnD = pending[RsnD] && !(WriteEnableW && WriteRegW==RsnD && BYPASS_EN).
  - The retiring write is bypassed, so it is not reported busy.
  - With BYPASS_EN=0, the retiring register still reports busy for that cycle.
- AnyBusy: registered flag, updated on the same edge as the pending bits, = |pending_next.
- Address width: only the low 5 bits are used. NREGS is fixed at 32 for RV32I. No out-of-range handling is required.

Test Plan:
- Reset mid-run:
  - Stimulus: write x5=0xDEADBEEF, issue x7, then drop rst_n asynchronously between edges.
  - Required: RD1D(Rs1D=5)=0 and BusyRs1D(Rs1D=7)=0 before the next edge; AnyBusy=0.
- Basic write/read:
  - Stimulus: WriteEnableW=1, WriteRegW=3, WriteDataW=0x12345678, one edge; then Rs1D=3, Rs2D=3.
  - Required: RD1D=RD2D=0x12345678.
- x0 protection:
  - Stimulus: write x0=0xFFFFFFFF, and in the same cycle read Rs1D=0.
  - Required: RD1D=0 in that cycle and after. Also IssueValidD with IssueRdD=0 leaves BusyRs1D(Rs1D=0)=0.
- Bypass:
  - Stimulus: x9 holds 0xA, WriteRegW=9, WriteDataW=0xB, WriteEnableW=1, Rs2D=9 in the same cycle.
  - Required: with BYPASS_EN=1, RD2D=0xB; with BYPASS_EN=0, RD2D=0xA, and 0xB after the edge.
- Scoreboard lifecycle:
  - Stimulus: issue x4 at cycle 0; writeback x4=0x55 at cycle 3.
  - Required: BusyRs1D(Rs1D=4)=1 during cycles 1-2. In cycle 3, BusyRs1D=0 (bypass) and RD1D=0x55. After cycle 3, AnyBusy=0.
- Simultaneous set/clear:
  - Stimulus: x6 pending, then in one cycle writeback x6 and issue x6.
  - Required: after the edge, pending[6]=1, BusyRs1D(Rs1D=6)=1, AnyBusy=1, regs[6]=written value.
